// File: rtl/lfsr_draw_gen.sv
// lfsr_draw_gen
//   Fibonacci XNOR LFSR with seed load and all-ones lock-up recovery, plus a
//   request/valid draw engine that returns a filtered value in [0, RANGE-1],
//   optionally never repeating the previous draw. Used by the game FSM to pick
//   mole positions; the raw LFSR state is exported for other consumers.
//
// Ports
//   clock       system clock, all logic on posedge
//   reset       synchronous, active-high reset
//   enable      free-run advance of the LFSR while the draw FSM is idle
//   load        load seed_in into the LFSR (aborts a draw in progress)
//   seed_in     seed value for load
//   req         draw request, level-sampled while idle
//   busy        high while a draw is in progress
//   valid       one-cycle pulse when value has been updated
//   value       last drawn value, held between valid pulses
//   fallback    one-cycle pulse with valid when the fallback value was used
//   lockup      one-cycle pulse when the all-ones state was recovered
//   lfsr_state  current LFSR register
module lfsr_draw_gen #(
    parameter int unsigned       WIDTH     = 16,
    parameter logic [WIDTH-1:0]  TAPS      = 16'hA404,
    parameter logic [WIDTH-1:0]  SEED      = 16'h0000,
    parameter int unsigned       OUT_W     = 4,
    parameter int unsigned       RANGE     = 9,
    parameter int unsigned       NO_REPEAT = 1,
    parameter int unsigned       MAX_TRIES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] value,
    output logic             fallback,
    output logic             lockup,
    output logic [WIDTH-1:0] lfsr_state
);

    // tries only ever counts up to MAX_TRIES-1
    localparam int unsigned      TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
    // one extra bit so RANGE == 2**OUT_W is representable
    localparam logic [OUT_W:0]   RANGE_X  = (OUT_W + 1)'(RANGE);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [OUT_W-1:0]   last_q, last_d;
    logic               have_last_q, have_last_d;
    logic [OUT_W-1:0]   value_q, value_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               fallback_q, fallback_d;
    logic               lockup_q, lockup_d;

    logic               fb;
    logic               advance;
    logic [OUT_W-1:0]   cand;
    logic               is_repeat;
    logic               accept;
    logic [OUT_W:0]     last_inc;
    logic [OUT_W-1:0]   fb_value;

    always_comb begin
        // XNOR feedback: all-ones is the only state that maps onto itself
        fb        = ~^(s_q & TAPS);
        advance   = ((state_q == IDLE) && enable) || (state_q == DRAW);
        cand      = s_q[OUT_W-1:0];
        is_repeat = (NO_REPEAT != 0) && (RANGE > 1) && have_last_q && (cand == last_q);
        accept    = ({1'b0, cand} < RANGE_X) && !is_repeat;
        last_inc  = {1'b0, last_q} + 1'b1;
        if (!have_last_q || (last_inc == RANGE_X)) fb_value = '0;
        else                                        fb_value = last_inc[OUT_W-1:0];

        s_d         = s_q;
        state_d     = state_q;
        tries_d     = tries_q;
        last_d      = last_q;
        have_last_d = have_last_q;
        value_d     = value_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        fallback_d  = 1'b0;
        lockup_d    = 1'b0;

        // LFSR register: load > lock-up recovery > advance
        if (load) begin
            s_d = seed_in;
        end else if (advance) begin
            if (&s_q) begin
                s_d      = SEED;
                lockup_d = 1'b1;
            end else begin
                s_d = {s_q[WIDTH-2:0], fb};
            end
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = DRAW;
                    busy_d  = 1'b1;
                    tries_d = '0;
                end
            end
            DRAW: begin
                if (load) begin
                    // abort: history of the previous successful draw is kept
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    tries_d = '0;
                end else if (accept) begin
                    value_d     = cand;
                    last_d      = cand;
                    have_last_d = 1'b1;
                    valid_d     = 1'b1;
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    tries_d     = '0;
                end else if (tries_q == TRY_LAST) begin
                    // bound the draw latency to MAX_TRIES evaluations
                    value_d     = fb_value;
                    last_d      = fb_value;
                    have_last_d = 1'b1;
                    valid_d     = 1'b1;
                    fallback_d  = 1'b1;
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    tries_d     = '0;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= SEED;
            tries_q     <= '0;
            last_q      <= '0;
            have_last_q <= 1'b0;
            value_q     <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            fallback_q  <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            tries_q     <= tries_d;
            last_q      <= last_d;
            have_last_q <= have_last_d;
            value_q     <= value_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            fallback_q  <= fallback_d;
            lockup_q    <= lockup_d;
        end
    end

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign value      = value_q;
    assign fallback   = fallback_q;
    assign lockup     = lockup_q;
    assign lfsr_state = s_q;

endmodule
